// File: rtl/mbone_wb_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with per-grant ACK watchdog.
// The grant is held for the owner's whole CYC so multi-beat cycles stay atomic.
module mbone_wb_arbiter #(
  parameter int g_timeout = 1023
) (
  input  logic        clk_sys_i,
  input  logic        rst_i,

  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,

  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,

  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [15:0] c_wdog_limit = 16'(g_timeout - 1);

  state_t      state;
  logic [1:0]  owner;
  logic        last_m1;
  logic [15:0] wdog_cnt;
  logic        tmo_q;

  logic        req0;
  logic        req1;
  logic        in_grant;
  logic        in_abort;
  logic        own_cyc;
  logic        own_stb;
  logic        own_we;
  logic [3:0]  own_sel;
  logic [31:0] own_adr;
  logic [31:0] own_dat;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Owner's request signals, selected by the registered grant.
  assign own_cyc = owner[1] ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner[1] ? m1_stb_i : m0_stb_i;
  assign own_we  = owner[1] ? m1_we_i  : m0_we_i;
  assign own_sel = owner[1] ? m1_sel_i : m0_sel_i;
  assign own_adr = owner[1] ? m1_adr_i : m0_adr_i;
  assign own_dat = owner[1] ? m1_dat_i : m0_dat_i;

  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      state    <= IDLE;
      owner    <= 2'b00;
      last_m1  <= 1'b1;
      wdog_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        IDLE: begin
          wdog_cnt <= '0;
          // last is updated on every grant so a waiting master always goes next
          if (req0 && (!req1 || last_m1)) begin
            owner   <= 2'b01;
            last_m1 <= 1'b0;
            state   <= GRANT;
          end else if (req1) begin
            owner   <= 2'b10;
            last_m1 <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!own_cyc) begin
            state    <= IDLE;
            owner    <= 2'b00;
            wdog_cnt <= '0;
          end else if (!own_stb || s_ack_i) begin
            wdog_cnt <= '0;
          end else if (wdog_cnt == c_wdog_limit) begin
            state    <= ABORT;
            wdog_cnt <= '0;
            tmo_q    <= 1'b1;
          end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
          end
        end
        ABORT: begin
          state <= IDLE;
          owner <= 2'b00;
        end
        default: begin
          state <= IDLE;
          owner <= 2'b00;
        end
      endcase
    end
  end

  assign in_grant = (state == GRANT);
  assign in_abort = (state == ABORT);

  assign s_cyc_o = in_grant & own_cyc;
  assign s_stb_o = in_grant & own_stb;
  assign s_we_o  = in_grant & own_we;
  assign s_sel_o = in_grant ? own_sel : 4'h0;
  assign s_adr_o = in_grant ? own_adr : 32'h0;
  assign s_dat_o = in_grant ? own_dat : 32'h0;

  assign m0_ack_o = in_grant & owner[0] & s_ack_i;
  assign m1_ack_o = in_grant & owner[1] & s_ack_i;
  assign m0_err_o = in_abort & owner[0];
  assign m1_err_o = in_abort & owner[1];
  assign m0_dat_o = (in_grant & owner[0]) ? s_dat_i : 32'h0;
  assign m1_dat_o = (in_grant & owner[1]) ? s_dat_i : 32'h0;

  assign grant_o   = owner;
  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_mbone_wb_arbiter.sv
// Directed bench for mbone_wb_arbiter: memory slave with programmable ACK delay,
// two masters driven cycle by cycle, expected values written out by hand.
module tb_mbone_wb_arbiter;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;

  logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [3:0]  m0_sel = 4'h0;
  logic [31:0] m0_adr = 32'h0, m0_dat = 32'h0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdat;

  logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [3:0]  m1_sel = 4'h0;
  logic [31:0] m1_adr = 32'h0, m1_dat = 32'h0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdat;

  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat;
  logic [31:0] s_rdat = 32'h0;
  logic        s_ack = 1'b0;

  logic [1:0]  grant;
  logic        timeout;

  int errors = 0;
  int checks = 0;
  int ack0_n = 0, ack1_n = 0, err0_n = 0, err1_n = 0, tmo_n = 0;

  logic        slv_en = 1'b1;
  int          slv_wait = 0;
  int          wcnt = 0;
  logic [31:0] mem [0:255];

  always #5 clk_sys = ~clk_sys;

  mbone_wb_arbiter #(.g_timeout(8)) dut (
    .clk_sys_i(clk_sys), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack),
    .grant_o(grant), .timeout_o(timeout)
  );

  // Memory slave: ACK arrives slv_wait+1 cycles after the strobe is first seen.
  always @(posedge clk_sys) begin
    if (slv_en && s_cyc && s_stb && !s_ack) begin
      if (wcnt == slv_wait) begin
        s_ack  <= 1'b1;
        wcnt   <= 0;
        s_rdat <= mem[s_adr[7:0]];
        if (s_we)
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr[7:0]][8*b +: 8] <= s_wdat[8*b +: 8];
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      s_ack <= 1'b0;
      if (!(s_cyc && s_stb)) wcnt <= 0;
    end
  end

  always @(posedge clk_sys) begin
    if (m0_ack === 1'b1) ack0_n <= ack0_n + 1;
    if (m1_ack === 1'b1) ack1_n <= ack1_n + 1;
    if (m0_err === 1'b1) err0_n <= err0_n + 1;
    if (m1_err === 1'b1) err1_n <= err1_n + 1;
    if (timeout === 1'b1) tmo_n <= tmo_n + 1;
  end

  task automatic nxt();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_masters();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'h0; m0_adr = 32'h0; m0_dat = 32'h0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'h0; m1_adr = 32'h0; m1_dat = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_masters();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk_sys);
    checks++;
    if ({s_cyc, s_stb, s_we, s_sel, m0_ack, m0_err, m1_ack, m1_err, timeout, grant} !== 14'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %h want 0", {s_cyc, s_stb, s_we, s_sel, m0_ack, m0_err, m1_ack, m1_err, timeout, grant});
    end
    checks++;
    if ({s_adr, s_wdat, m0_rdat, m1_rdat} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {s_adr, s_wdat, m0_rdat, m1_rdat});
    end
    nxt();
  endtask

  task automatic test_write_read();
    int a0;
    a0 = ack0_n;
    slv_wait = 0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF;
    m0_adr = 32'h10; m0_dat = 32'hDEADBEEF;
    @(negedge clk_sys);
    checks++;
    if (s_cyc !== 1'b0) begin
      errors++; $display("FAIL wr_latency: s_cyc got %b want 0", s_cyc);
    end
    nxt();
    @(negedge clk_sys);
    checks++;
    if ({grant, s_cyc, s_stb, s_we} !== 5'b01_111) begin
      errors++; $display("FAIL wr_grant: got %b want 01111", {grant, s_cyc, s_stb, s_we});
    end
    checks++;
    if ({s_adr, s_wdat, s_sel} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
      errors++; $display("FAIL wr_bus: got %h want %h", {s_adr, s_wdat, s_sel}, {32'h10, 32'hDEADBEEF, 4'hF});
    end
    nxt();
    @(negedge clk_sys);
    checks++;
    if (m0_ack !== 1'b1) begin
      errors++; $display("FAIL wr_ack: got %b want 1", m0_ack);
    end
    nxt();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    nxt();
    @(negedge clk_sys);
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL wr_release: grant got %b want 00", grant);
    end
    checks++;
    if (ack0_n - a0 !== 1) begin
      errors++; $display("FAIL wr_ack_count: got %0d want 1", ack0_n - a0);
    end
    checks++;
    if (mem[8'h10] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_mem: got %h want deadbeef", mem[8'h10]);
    end
    nxt();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h10;
    nxt();
    nxt();
    @(negedge clk_sys);
    checks++;
    if ({m0_ack, m0_rdat} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_data: got %h want %h", {m0_ack, m0_rdat}, {1'b1, 32'hDEADBEEF});
    end
    checks++;
    if ({m1_ack, m1_rdat} !== 33'h0) begin
      errors++; $display("FAIL rd_nonowner: got %h want 0", {m1_ack, m1_rdat});
    end
    nxt();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    nxt();
  endtask

  task automatic test_tie();
    do_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF; m0_adr = 32'h20; m0_dat = 32'h11112222;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF; m1_adr = 32'h30; m1_dat = 32'h33334444;
    nxt();
    @(negedge clk_sys);
    checks++;
    if ({grant, m1_ack} !== 3'b010) begin
      errors++; $display("FAIL tie_first: got %b want 010", {grant, m1_ack});
    end
    nxt();
    nxt();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    nxt();
    @(negedge clk_sys);
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL tie_gap: grant got %b want 00", grant);
    end
    nxt();
    @(negedge clk_sys);
    checks++;
    if ({grant, s_adr} !== {2'b10, 32'h30}) begin
      errors++; $display("FAIL tie_second: got %h want %h", {grant, s_adr}, {2'b10, 32'h30});
    end
    nxt();
    @(negedge clk_sys);
    checks++;
    if ({m1_ack, m0_ack} !== 2'b10) begin
      errors++; $display("FAIL tie_m1_ack: got %b want 10", {m1_ack, m0_ack});
    end
    nxt();
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    nxt();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    logic seen0, seen1;
    int bad;
    bad = 0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF; m0_adr = 32'h40; m0_dat = 32'hA0A0A0A0;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF; m1_adr = 32'h44; m1_dat = 32'hB1B1B1B1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk_sys);
      if (i == 0) exp = 2'b00;
      else case ((i - 1) % 8)
        0, 1, 2: exp = 2'b01;
        3, 7:    exp = 2'b00;
        default: exp = 2'b10;
      endcase
      checks++;
      if (grant !== exp) begin
        errors++; $display("FAIL rr_grant cycle %0d: got %b want %b", i, grant, exp);
      end
      if (grant == 2'b01 && m1_ack !== 1'b0) bad++;
      seen0 = m0_ack;
      seen1 = m1_ack;
      nxt();
      if (!m0_cyc) begin m0_cyc = 1'b1; m0_stb = 1'b1; end
      else if (seen0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
      if (!m1_cyc) begin m1_cyc = 1'b1; m1_stb = 1'b1; end
      else if (seen1) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL rr_m1_ack_during_m0: got %0d want 0", bad);
    end
    clear_masters();
    nxt();
    nxt();
  endtask

  task automatic test_hold();
    int beats, n;
    logic bad;
    beats = 0; n = 0; bad = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_sel = 4'hF; m0_adr = 32'h0; m0_dat = 32'h100;
    nxt();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'hA0;
    while (beats < 4 && n < 40) begin
      @(negedge clk_sys);
      if (grant == 2'b10 || (s_cyc && s_adr == 32'hA0)) bad = 1'b1;
      if (m0_ack === 1'b1) beats++;
      nxt();
      n++;
      m0_adr = 32'(beats);
      m0_dat = 32'h100 + 32'(beats);
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    checks++;
    if (beats !== 4) begin
      errors++; $display("FAIL hold_beats: got %0d want 4", beats);
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL hold_atomic: m1 seen on bus got %b want 0", bad);
    end
    checks++;
    if (mem[3] !== 32'h103) begin
      errors++; $display("FAIL hold_mem: got %h want 00000103", mem[3]);
    end
    nxt();
    @(negedge clk_sys);
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL hold_gap: grant got %b want 00", grant);
    end
    nxt();
    @(negedge clk_sys);
    checks++;
    if ({grant, s_cyc, s_adr} !== {2'b10, 1'b1, 32'hA0}) begin
      errors++; $display("FAIL hold_m1_grant: got %h want %h", {grant, s_cyc, s_adr}, {2'b10, 1'b1, 32'hA0});
    end
    nxt();
    nxt();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    nxt();
  endtask

  task automatic test_timeout();
    int e0, e1, t0;
    logic early;
    e0 = err0_n; e1 = err1_n; t0 = tmo_n; early = 1'b0;
    slv_en = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h40;
    nxt();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'hB0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk_sys);
      if (s_cyc !== 1'b1 || grant !== 2'b01 || m0_err !== 1'b0 || timeout !== 1'b0) early = 1'b1;
      nxt();
    end
    @(negedge clk_sys);
    checks++;
    if ({s_cyc, s_stb, m0_err, timeout} !== 4'b0011) begin
      errors++; $display("FAIL to_abort: got %b want 0011", {s_cyc, s_stb, m0_err, timeout});
    end
    checks++;
    if ({m0_ack, m1_ack, m1_err} !== 3'b000) begin
      errors++; $display("FAIL to_abort_quiet: got %b want 000", {m0_ack, m1_ack, m1_err});
    end
    nxt();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk_sys);
    checks++;
    if (grant !== 2'b00) begin
      errors++; $display("FAIL to_release: grant got %b want 00", grant);
    end
    nxt();
    @(negedge clk_sys);
    checks++;
    if ({grant, s_adr} !== {2'b10, 32'hB0}) begin
      errors++; $display("FAIL to_next_owner: got %h want %h", {grant, s_adr}, {2'b10, 32'hB0});
    end
    nxt();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    nxt();
    checks++;
    if (early !== 1'b0) begin
      errors++; $display("FAIL to_wait: early abort or drop got %b want 0", early);
    end
    checks++;
    if ({err0_n - e0, tmo_n - t0, err1_n - e1} !== {32'd1, 32'd1, 32'd0}) begin
      errors++; $display("FAIL to_pulse_count: err0 %0d tmo %0d err1 %0d want 1 1 0", err0_n - e0, tmo_n - t0, err1_n - e1);
    end
    slv_en = 1'b1;
  endtask

  task automatic test_threshold_ack();
    int e0, t0;
    e0 = err0_n; t0 = tmo_n;
    slv_wait = 6;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h10;
    repeat (8) nxt();
    @(negedge clk_sys);
    checks++;
    if ({m0_ack, m0_err, m0_rdat} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL thr_ack: got %h want %h", {m0_ack, m0_err, m0_rdat}, {1'b1, 1'b0, 32'hDEADBEEF});
    end
    nxt();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({m0_err, timeout, s_cyc} !== 3'b000) begin
      errors++; $display("FAIL thr_no_abort: got %b want 000", {m0_err, timeout, s_cyc});
    end
    nxt();
    checks++;
    if ({err0_n - e0, tmo_n - t0} !== 64'h0) begin
      errors++; $display("FAIL thr_no_err: err0 %0d tmo %0d want 0 0", err0_n - e0, tmo_n - t0);
    end
    slv_wait = 0;
  endtask

  task automatic test_reset_mid();
    int a1, e1;
    a1 = ack1_n; e1 = err1_n;
    slv_wait = 3;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF; m1_adr = 32'h50; m1_dat = 32'h5555;
    nxt();
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    @(negedge clk_sys);
    checks++;
    if ({s_cyc, s_stb, s_we, s_sel, m0_ack, m0_err, m1_ack, m1_err, timeout, grant} !== 14'h0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got %h want 0", {s_cyc, s_stb, s_we, s_sel, m0_ack, m0_err, m1_ack, m1_err, timeout, grant});
    end
    checks++;
    if ({s_adr, s_wdat, m1_rdat} !== 96'h0) begin
      errors++; $display("FAIL rst_mid_data: got %h want 0", {s_adr, s_wdat, m1_rdat});
    end
    slv_wait = 0;
    nxt();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h60;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h64;
    nxt();
    @(negedge clk_sys);
    checks++;
    if (grant !== 2'b01) begin
      errors++; $display("FAIL rst_tie: grant got %b want 01", grant);
    end
    checks++;
    if ({ack1_n - a1, err1_n - e1} !== 64'h0) begin
      errors++; $display("FAIL rst_mid_no_ack_err: ack1 %0d err1 %0d want 0 0", ack1_n - a1, err1_n - e1);
    end
    nxt();
    nxt();
    clear_masters();
    nxt();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_tie();
    test_round_robin();
    test_hold();
    test_timeout();
    test_threshold_ack();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: bench did not reach its summary within 100000 time units");
    $fatal(1);
  end

endmodule
